// File: rtl/traffic_monitor_if.sv
// Observation bus between the light controller outputs and the traffic monitor.
// master drives the sampled heads and clear; slave is the monitor reporting status.
interface traffic_monitor_if #(
    parameter int CNT_W = 8
);
    logic             clr;
    logic [3:0]       car_traffic;
    logic [1:0]       walk_traffic;
    logic [2:0]       phase;
    logic             locked;
    logic             cycle_done;
    logic [CNT_W-1:0] period;
    logic [3:0]       err;

    modport master (
        output clr, car_traffic, walk_traffic,
        input  phase, locked, cycle_done, period, err
    );

    modport slave (
        input  clr, car_traffic, walk_traffic,
        output phase, locked, cycle_done, period, err
    );
endinterface

// File: rtl/traffic_monitor.sv
// Passive checker of the traffic-light heads: decodes car phase, times each run and the period, keeps sticky errors.
// One clock latency, every output registered; purely observing, it never stalls or backpressures the controller.
module traffic_monitor #(
    parameter int T_GREEN  = 20,
    parameter int T_YELLOW = 2,
    parameter int T_LEFT   = 10,
    parameter int T_RED    = 34,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             start,
    traffic_monitor_if.slave bus
);

    typedef enum logic [2:0] {
        PH_UNK   = 3'd0,
        PH_GREEN = 3'd1,
        PH_Y1    = 3'd2,
        PH_LEFT  = 3'd3,
        PH_Y2    = 3'd4,
        PH_RED   = 3'd5
    } phase_e;

    localparam logic [3:0] CAR_RED   = 4'b1000;
    localparam logic [3:0] CAR_YEL   = 4'b0100;
    localparam logic [3:0] CAR_LEFT  = 4'b0010;
    localparam logic [3:0] CAR_GREEN = 4'b0001;

    localparam logic [1:0] WALK_RED   = 2'b10;
    localparam logic [1:0] WALK_GREEN = 2'b01;
    localparam logic [1:0] WALK_OFF   = 2'b00;
    localparam logic [1:0] WALK_BAD   = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] RUN_GREEN  = CNT_W'(T_GREEN);
    localparam logic [CNT_W-1:0] RUN_YELLOW = CNT_W'(T_YELLOW);
    localparam logic [CNT_W-1:0] RUN_LEFT   = CNT_W'(T_LEFT);
    localparam logic [CNT_W-1:0] RUN_RED    = CNT_W'(T_RED);

    phase_e           phase_q,      phase_d;
    logic [3:0]       car_q;
    logic [1:0]       walk_q;
    logic [CNT_W-1:0] run_len_q,    run_len_d;
    logic             run_valid_q,  run_valid_d;
    logic [CNT_W-1:0] per_cnt_q,    per_cnt_d;
    logic             per_valid_q,  per_valid_d;
    logic [CNT_W-1:0] period_q,     period_d;
    logic             locked_q,     locked_d;
    logic             cycle_done_q, cycle_done_d;
    logic [3:0]       err_q,        err_d;

    logic [3:0]       err_set;
    logic             lock_set;
    logic             green_entry;
    logic             code_ok;
    logic             enc_bad;
    logic             hold;
    logic             enter_red;
    logic             walk_go;
    phase_e           code_phase;
    phase_e           succ_phase;
    logic [3:0]       want_code;
    logic [CNT_W-1:0] run_req;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign code_ok   = (bus.car_traffic == CAR_RED)  || (bus.car_traffic == CAR_YEL) ||
                       (bus.car_traffic == CAR_LEFT) || (bus.car_traffic == CAR_GREEN);
    assign enc_bad   = !code_ok || (bus.walk_traffic == WALK_BAD);
    assign hold      = (bus.car_traffic == car_q);
    assign enter_red = (bus.car_traffic == CAR_RED) && (car_q != CAR_RED);
    assign walk_go   = (walk_q == WALK_RED) && (bus.walk_traffic == WALK_GREEN);

    // Phase a raw code lands in when no sequence context applies; YELLOW is ambiguous.
    always_comb begin
        code_phase = PH_UNK;
        case (bus.car_traffic)
            CAR_GREEN: code_phase = PH_GREEN;
            CAR_LEFT:  code_phase = PH_LEFT;
            CAR_RED:   code_phase = PH_RED;
            default:   code_phase = PH_UNK;
        endcase
    end

    always_comb begin
        want_code  = CAR_GREEN;
        succ_phase = PH_UNK;
        run_req    = '0;
        case (phase_q)
            PH_GREEN: begin want_code = CAR_YEL;   succ_phase = PH_Y1;    run_req = RUN_GREEN;  end
            PH_Y1:    begin want_code = CAR_LEFT;  succ_phase = PH_LEFT;  run_req = RUN_YELLOW; end
            PH_LEFT:  begin want_code = CAR_YEL;   succ_phase = PH_Y2;    run_req = RUN_LEFT;   end
            PH_Y2:    begin want_code = CAR_RED;   succ_phase = PH_RED;   run_req = RUN_YELLOW; end
            PH_RED:   begin want_code = CAR_GREEN; succ_phase = PH_GREEN; run_req = RUN_RED;    end
            default:  ;
        endcase
    end

    always_comb begin
        phase_d      = phase_q;
        run_len_d    = hold ? sat_inc(run_len_q) : CNT_ONE;
        run_valid_d  = run_valid_q;
        per_valid_d  = per_valid_q;
        period_d     = period_q;
        cycle_done_d = 1'b0;
        err_set      = '0;
        lock_set     = 1'b0;
        green_entry  = 1'b0;

        if (enc_bad) begin
            err_set[0]  = 1'b1;
            phase_d     = PH_UNK;
            run_valid_d = 1'b0;
            per_valid_d = 1'b0;
        end else if (!hold) begin
            if (phase_q == PH_UNK) begin
                phase_d     = code_phase;
                run_valid_d = 1'b0;
            end else if (bus.car_traffic != want_code) begin
                err_set[2]  = 1'b1;
                phase_d     = code_phase;
                run_valid_d = 1'b0;
            end else begin
                phase_d     = succ_phase;
                run_valid_d = 1'b1;
                lock_set    = 1'b1;
                // Only a run entered through a legal step has a trustworthy length.
                if (run_valid_q && (run_len_q != run_req)) begin
                    err_set[3] = 1'b1;
                end
                if (phase_q == PH_RED) begin
                    green_entry  = 1'b1;
                    cycle_done_d = 1'b1;
                    per_valid_d  = 1'b1;
                    if (per_valid_q) begin
                        period_d = sat_inc(per_cnt_q);
                    end
                end
            end
        end

        per_cnt_d = green_entry ? '0 : sat_inc(per_cnt_q);

        if (((bus.walk_traffic == WALK_GREEN) || (bus.walk_traffic == WALK_OFF)) &&
            (bus.car_traffic != CAR_RED)) begin
            err_set[1] = 1'b1;
        end
        if (walk_go && !enter_red) begin
            err_set[2] = 1'b1;
        end

        // Clear wins over anything detected on the same edge; a fresh error beats a lock.
        if (bus.clr) begin
            err_d    = '0;
            locked_d = 1'b0;
        end else begin
            err_d    = err_q | err_set;
            locked_d = (|err_set) ? 1'b0 : (lock_set ? 1'b1 : locked_q);
        end
    end

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            phase_q      <= PH_UNK;
            car_q        <= '0;
            walk_q       <= WALK_RED;
            run_len_q    <= '0;
            run_valid_q  <= 1'b0;
            per_cnt_q    <= '0;
            per_valid_q  <= 1'b0;
            period_q     <= '0;
            locked_q     <= 1'b0;
            cycle_done_q <= 1'b0;
            err_q        <= '0;
        end else begin
            phase_q      <= phase_d;
            car_q        <= bus.car_traffic;
            walk_q       <= bus.walk_traffic;
            run_len_q    <= run_len_d;
            run_valid_q  <= run_valid_d;
            per_cnt_q    <= per_cnt_d;
            per_valid_q  <= per_valid_d;
            period_q     <= period_d;
            locked_q     <= locked_d;
            cycle_done_q <= cycle_done_d;
            err_q        <= err_d;
        end
    end

    assign bus.phase      = phase_q;
    assign bus.locked     = locked_q;
    assign bus.cycle_done = cycle_done_q;
    assign bus.period     = period_q;
    assign bus.err        = err_q;

endmodule
